// File: rtl/slip_tx_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | slip_tx_fifo_pkg                                                   |
// | SLIP byte codes, encoder FSM states and the CRC-16 byte step.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package slip_tx_fifo_pkg;

   localparam logic [7:0]  SLIP_END     = 8'hC0;
   localparam logic [7:0]  SLIP_ESC     = 8'hDB;
   localparam logic [7:0]  SLIP_ESC_END = 8'hDC;
   localparam logic [7:0]  SLIP_ESC_ESC = 8'hDD;
   localparam logic [15:0] CRC_INIT     = 16'hFFFF;
   localparam logic [15:0] CRC_POLY     = 16'h1021;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DATA   = 3'd1,
      S_ESC2   = 3'd2,
      S_CRC_HI = 3'd3,
      S_CRC_LO = 3'd4,
      S_END    = 3'd5
   } slip_state_e;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } fifo_entry_t;

   // CRC-16/CCITT-FALSE, one byte, MSB first
   function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc,
                                                    input logic [7:0]  data_byte);
      logic [15:0] c;
      c = crc ^ {data_byte, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      end
      return c;
   endfunction

   function automatic logic needs_escape(input logic [7:0] b);
      return (b == SLIP_END) || (b == SLIP_ESC);
   endfunction

   function automatic logic [7:0] esc_code(input logic [7:0] b);
      return (b == SLIP_END) ? SLIP_ESC_END : SLIP_ESC_ESC;
   endfunction

endpackage
`default_nettype wire

// File: rtl/slip_tx_fifo_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | slip_tx_fifo_sync_fifo                                             |
// | Single-clock FIFO, registered full/empty, combinational read port. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module slip_tx_fifo_sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int             c_aw    = $clog2(DEPTH);
   localparam logic [c_aw:0]  c_depth = (c_aw+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_aw:0]    r_count;
   logic             r_full;
   logic             r_empty;
   logic             w_push;
   logic             w_pop;
   logic [c_aw:0]    w_count_nxt;

   assign w_push    = i_push && !r_full;
   assign w_pop     = i_pop && !r_empty;
   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_full    = r_full;
   assign o_empty   = r_empty;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + (c_aw+1)'(1);
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - (c_aw+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // flags derive from the next count so they are valid right after the edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == c_depth);
         r_empty <= (w_count_nxt == '0);
      end
   end

endmodule
`default_nettype wire

// File: rtl/slip_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | slip_tx_fifo                                                       |
// | Buffered SLIP transmit encoder with optional CRC-16 trailer.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module slip_tx_fifo
   import slip_tx_fifo_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int LEAD_END   = 1,
   parameter int APPEND_CRC = 0,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt
);

   slip_state_e      r_state;
   slip_state_e      r_ret;
   logic [7:0]       r_esc2;
   logic [15:0]      r_crc;
   logic [7:0]       r_out_data;
   logic             r_out_valid;
   logic             r_out_tail;
   logic [CNT_W-1:0] r_frame_cnt;

   slip_state_e      w_state_nxt;
   slip_state_e      w_ret_nxt;
   slip_state_e      w_data_ret;
   slip_state_e      w_crc_ret;
   logic [7:0]       w_esc2_nxt;
   logic [15:0]      w_crc_nxt;
   logic [7:0]       w_crc_byte;
   logic             w_emit;
   logic [7:0]       w_byte;
   logic             w_tail;
   logic             w_pop;
   logic             w_load;
   logic             w_full;
   logic             w_empty;
   fifo_entry_t      w_entry;

   slip_tx_fifo_sync_fifo #(
      .WIDTH (9),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (in_valid),
      .i_wr_data ({in_last, in_data}),
      .i_pop     (w_pop),
      .o_rd_data (w_entry),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   assign in_ready   = !w_full;
   assign out_data   = r_out_data;
   assign out_valid  = r_out_valid;
   assign frame_cnt  = r_frame_cnt;
   assign busy       = (r_state != S_IDLE) || !w_empty;
   assign w_load     = !r_out_valid || out_ready;

   assign w_data_ret = w_entry.last ? ((APPEND_CRC != 0) ? S_CRC_HI : S_END) : S_DATA;
   assign w_crc_ret  = (r_state == S_CRC_HI) ? S_CRC_LO : S_END;
   assign w_crc_byte = (r_state == S_CRC_HI) ? r_crc[15:8] : r_crc[7:0];

   always_comb begin
      w_state_nxt = r_state;
      w_ret_nxt   = r_ret;
      w_esc2_nxt  = r_esc2;
      w_crc_nxt   = r_crc;
      w_emit      = 1'b0;
      w_byte      = 8'h00;
      w_tail      = 1'b0;
      w_pop       = 1'b0;
      if (w_load) begin
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  w_state_nxt = S_DATA;
                  if (LEAD_END != 0) begin
                     w_emit = 1'b1;
                     w_byte = SLIP_END;
                  end
               end
            end
            S_DATA: begin
               // an empty FIFO mid-frame just stalls; no END is inserted
               if (!w_empty) begin
                  w_pop     = 1'b1;
                  w_crc_nxt = crc16_ccitt_byte(r_crc, w_entry.data);
                  w_emit    = 1'b1;
                  w_ret_nxt = w_data_ret;
                  if (needs_escape(w_entry.data)) begin
                     w_byte      = SLIP_ESC;
                     w_esc2_nxt  = esc_code(w_entry.data);
                     w_state_nxt = S_ESC2;
                  end else begin
                     w_byte      = w_entry.data;
                     w_state_nxt = w_data_ret;
                  end
               end
            end
            S_ESC2: begin
               w_emit      = 1'b1;
               w_byte      = r_esc2;
               w_state_nxt = r_ret;
            end
            S_CRC_HI, S_CRC_LO: begin
               w_emit    = 1'b1;
               w_ret_nxt = w_crc_ret;
               if (needs_escape(w_crc_byte)) begin
                  w_byte      = SLIP_ESC;
                  w_esc2_nxt  = esc_code(w_crc_byte);
                  w_state_nxt = S_ESC2;
               end else begin
                  w_byte      = w_crc_byte;
                  w_state_nxt = w_crc_ret;
               end
            end
            S_END: begin
               w_emit      = 1'b1;
               w_byte      = SLIP_END;
               w_tail      = 1'b1;
               w_crc_nxt   = CRC_INIT;
               w_state_nxt = S_IDLE;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ret       <= S_IDLE;
         r_esc2      <= 8'h00;
         r_crc       <= CRC_INIT;
         r_out_data  <= 8'h00;
         r_out_valid <= 1'b0;
         r_out_tail  <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ret   <= w_ret_nxt;
         r_esc2  <= w_esc2_nxt;
         r_crc   <= w_crc_nxt;
         if (w_load) begin
            r_out_valid <= w_emit;
            if (w_emit) begin
               r_out_data <= w_byte;
               r_out_tail <= w_tail;
            end
         end
         // the lead END is also 0xC0, so only the tagged trailing END counts
         if (r_out_valid && out_ready && r_out_tail) begin
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_slip_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_slip_tx_fifo                                                    |
// | Two encoder configurations fed in lockstep, scoreboarded outputs.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_slip_tx_fifo;

   typedef struct {
      logic [7:0] b;
      bit         tail;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_last;
   logic        in_valid;
   logic        out_ready;

   logic        ir_a, ov_a, busy_a;
   logic [7:0]  od_a;
   logic [1:0]  fc_a;
   logic        ir_b, ov_b, busy_b;
   logic [7:0]  od_b;
   logic [15:0] fc_b;

   // A: small FIFO, lead END, CRC trailer, 2-bit counter
   slip_tx_fifo #(.DEPTH(4), .LEAD_END(1), .APPEND_CRC(1), .CNT_W(2)) u_a (
      .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
      .in_ready(ir_a), .out_data(od_a), .out_valid(ov_a), .out_ready(out_ready),
      .busy(busy_a), .frame_cnt(fc_a));

   // B: default depth, trailing END only, no CRC
   slip_tx_fifo #(.DEPTH(16), .LEAD_END(0), .APPEND_CRC(0), .CNT_W(16)) u_b (
      .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
      .in_ready(ir_b), .out_data(od_b), .out_valid(ov_b), .out_ready(out_ready),
      .busy(busy_b), .frame_cnt(fc_b));

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   exp_t        qa[$];
   exp_t        qb[$];
   bit          frame_open = 0;
   logic [15:0] mcrc = 16'hFFFF;
   int          frames_sent = 0;
   int          rdy_mode = 0;
   bit          mon_on = 0;
   int          ecnt_a = 0, ecnt_b = 0;
   bit          tail_a = 0, tail_b = 0, stall_a = 0, stall_b = 0;
   logic [7:0]  hold_a, hold_b;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // bit-serial LFSR form of CRC-16/CCITT-FALSE
   function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] b);
      logic [15:0] c;
      logic        fb;
      c = crc;
      for (int k = 7; k >= 0; k--) begin
         fb = c[15] ^ b[k];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ 16'h1021;
      end
      return c;
   endfunction

   task automatic add_exp(input int inst, input logic [7:0] b, input bit tail);
      exp_t e;
      e.b = b;
      e.tail = tail;
      if (inst == 0) qa.push_back(e);
      else           qb.push_back(e);
   endtask

   task automatic add_enc(input int inst, input logic [7:0] b);
      if (b == 8'hC0) begin
         add_exp(inst, 8'hDB, 0); add_exp(inst, 8'hDC, 0);
      end else if (b == 8'hDB) begin
         add_exp(inst, 8'hDB, 0); add_exp(inst, 8'hDD, 0);
      end else begin
         add_exp(inst, b, 0);
      end
   endtask

   task automatic send(input logic [7:0] b, input bit last);
      int waited = 0;
      if (!frame_open) begin
         add_exp(0, 8'hC0, 0);
         frame_open = 1;
         mcrc = 16'hFFFF;
      end
      mcrc = crc_step(mcrc, b);
      add_enc(0, b);
      add_enc(1, b);
      if (last) begin
         add_enc(0, mcrc[15:8]);
         add_enc(0, mcrc[7:0]);
         add_exp(0, 8'hC0, 1);
         add_exp(1, 8'hC0, 1);
         frame_open = 0;
         frames_sent++;
      end
      @(negedge clk);
      while (!(ir_a && ir_b) && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 2000) begin
         chk("in_ready_timeout", 32'd0, 32'd1);
         return;
      end
      in_data  = b;
      in_last  = last;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int waited = 0;
      while ((qa.size() != 0 || qb.size() != 0 || busy_a || busy_b) && waited < 4000) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 4000) chk("drain_timeout", 32'd0, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            if (tail_a) begin
               ecnt_a++;
               chk("frame_cnt_a", {30'd0, fc_a}, ecnt_a % 4);
               tail_a = 0;
            end
            if (stall_a) begin
               chk("hold_valid_a", {31'd0, ov_a}, 32'd1);
               chk("hold_data_a", {24'd0, od_a}, {24'd0, hold_a});
            end
            if (ov_a && out_ready) begin
               if (qa.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL extra_byte_a: got 0x%0h, expected no output at %0t", od_a, $time);
               end else begin
                  e = qa.pop_front();
                  chk("data_a", {24'd0, od_a}, {24'd0, e.b});
                  tail_a = e.tail;
               end
            end
            stall_a = ov_a && !out_ready;
            hold_a  = od_a;

            if (tail_b) begin
               ecnt_b++;
               chk("frame_cnt_b", {16'd0, fc_b}, ecnt_b % 65536);
               tail_b = 0;
            end
            if (stall_b) begin
               chk("hold_valid_b", {31'd0, ov_b}, 32'd1);
               chk("hold_data_b", {24'd0, od_b}, {24'd0, hold_b});
            end
            if (ov_b && out_ready) begin
               if (qb.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL extra_byte_b: got 0x%0h, expected no output at %0t", od_b, $time);
               end else begin
                  e = qb.pop_front();
                  chk("data_b", {24'd0, od_b}, {24'd0, e.b});
                  tail_b = e.tail;
               end
            end
            stall_b = ov_b && !out_ready;
            hold_b  = od_b;
         end
      end
   end

   initial begin
      #800000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      logic [7:0]  msg [9];
      logic [15:0] c;
      logic [15:0] found;
      int          waited;
      int          len;
      int          r;
      logic [7:0]  b;

      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; rdy_mode = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid_a", {31'd0, ov_a}, 32'd0);
      chk("rst_out_data_a",  {24'd0, od_a}, 32'd0);
      chk("rst_frame_cnt_a", {30'd0, fc_a}, 32'd0);
      chk("rst_in_ready_a",  {31'd0, ir_a}, 32'd1);
      chk("rst_busy_a",      {31'd0, busy_a}, 32'd0);
      chk("rst_out_valid_b", {31'd0, ov_b}, 32'd0);
      chk("rst_frame_cnt_b", {16'd0, fc_b}, 32'd0);
      #1 rst = 1'b0;
      mon_on = 1;

      // escaped payload bytes
      send(8'h01, 0); send(8'hC0, 0); send(8'hDB, 0); send(8'h02, 1);
      drain();
      chk("t1_frame_cnt_a", {30'd0, fc_a}, 32'd1);
      chk("t1_frame_cnt_b", {16'd0, fc_b}, 32'd1);

      // CRC check string "123456789"
      for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
      for (int i = 0; i < 9; i++) send(msg[i], i == 8);
      drain();

      // payloads whose CRC trailer bytes need escaping
      for (int sel = 0; sel < 3; sel++) begin
         found = 16'h0000;
         for (int x = 0; x < 65536; x++) begin
            c = crc_step(crc_step(16'hFFFF, 8'(x >> 8)), 8'(x));
            if ((sel == 0 && c[15:8] == 8'hC0) || (sel == 1 && c[15:8] == 8'hDB) ||
                (sel == 2 && c[7:0] == 8'hC0)) begin
               found = 16'(x);
               break;
            end
         end
         send(found[15:8], 0);
         send(found[7:0], 1);
         drain();
      end

      // back-pressure fills the 4-deep FIFO
      rdy_mode = 1;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 0);
      @(negedge clk);
      chk("t4_in_ready_full", {31'd0, ir_a}, 32'd0);
      chk("t4_lead_valid",    {31'd0, ov_a}, 32'd1);
      chk("t4_lead_data",     {24'd0, od_a}, 32'hC0);
      repeat (4) @(negedge clk);
      chk("t4_in_ready_held", {31'd0, ir_a}, 32'd0);
      rdy_mode = 0;
      send(8'hA4, 0);
      send(8'hA5, 1);
      drain();

      // reset while the second escape byte is pending
      send(8'hC0, 1);
      waited = 0;
      @(negedge clk);
      while (!(ov_a && od_a == 8'hDB) && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 200) chk("t6_esc_timeout", 32'd0, 32'd1);
      #1;
      rst = 1'b1;
      mon_on = 0;
      qa.delete(); qb.delete();
      tail_a = 0; tail_b = 0; stall_a = 0; stall_b = 0;
      ecnt_a = 0; ecnt_b = 0; frame_open = 0; frames_sent = 0;
      @(negedge clk);
      chk("t6_rst_out_valid_a", {31'd0, ov_a}, 32'd0);
      chk("t6_rst_out_valid_b", {31'd0, ov_b}, 32'd0);
      chk("t6_rst_frame_cnt_a", {30'd0, fc_a}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      mon_on = 1;
      send(8'h55, 1);
      drain();
      chk("t6_frame_cnt_a", {30'd0, fc_a}, 32'd1);
      chk("t6_frame_cnt_b", {16'd0, fc_b}, 32'd1);

      // random frames under random output stalls
      rdy_mode = 2;
      for (int f = 0; f < 200; f++) begin
         len = $urandom_range(1, 10);
         for (int i = 0; i < len; i++) begin
            r = $urandom_range(0, 7);
            b = (r == 0) ? 8'hC0 : (r == 1) ? 8'hDB : 8'($urandom);
            if ($urandom_range(0, 4) == 0) @(negedge clk);
            send(b, i == len - 1);
         end
      end
      drain();
      rdy_mode = 0;
      repeat (3) @(negedge clk);
      chk("final_frame_cnt_a", {30'd0, fc_a}, frames_sent % 4);
      chk("final_frame_cnt_b", {16'd0, fc_b}, frames_sent % 65536);
      chk("final_busy_a", {31'd0, busy_a}, 32'd0);
      chk("final_busy_b", {31'd0, busy_b}, 32'd0);
      chk("final_queue_a", qa.size(), 32'd0);
      chk("final_queue_b", qb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
